// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register file driving the matrix core (start, soft reset, DIM, irq).
// Latency: write commits one edge after both AW and W are held; read data one edge after AR.
// Backpressure: AW/W stall while held or while B is pending; AR stalls while R is pending.
module axi_lite_ctrl_regs #(
    parameter int unsigned DIM_RESET = 4,
    parameter int unsigned DIM_MAX   = 16
) (
    input  logic        ACLK,
    input  logic        ARST_N,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        busy_i,
    input  logic        done_i,
    output logic        start_o,
    output logic        soft_rst_o,
    output logic [7:0]  dim_o,
    output logic        irq_o
);

    localparam logic [7:0] DIM_RST_V   = 8'(DIM_RESET);
    localparam logic [7:0] DIM_MAX_V   = 8'(DIM_MAX);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] IDX_CTRL    = 3'd0;
    localparam logic [2:0] IDX_STATUS  = 3'd1;
    localparam logic [2:0] IDX_DIM     = 3'd2;
    localparam logic [2:0] IDX_CNT     = 3'd3;
    localparam logic [2:0] IDX_SCRATCH = 3'd4;

    logic        aw_held, w_held;
    logic [31:2] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        ie_q, done_q;
    logic [7:0]  dim_q;
    logic [31:0] done_cnt, scratch_q;
    logic        commit;

    // Byte-offset bits carry no meaning in this word-only map.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, awaddr[1:0], araddr[1:0]};

    assign awready = !aw_held && !bvalid;
    assign wready  = !w_held && !bvalid;
    assign arready = !rvalid;
    assign commit  = aw_held && w_held && !bvalid;
    assign dim_o   = dim_q;

    logic [2:0] widx;
    logic       wr_start, wr_srst, wr_ie_we, wr_done_clr, wr_dim_we;
    logic [3:0] wr_scratch_we;
    logic [1:0] wr_resp;

    always_comb begin
        widx          = aw_addr_q[4:2];
        wr_start      = 1'b0;
        wr_srst       = 1'b0;
        wr_ie_we      = 1'b0;
        wr_done_clr   = 1'b0;
        wr_dim_we     = 1'b0;
        wr_scratch_we = 4'b0000;
        wr_resp       = RESP_OKAY;
        if (|aw_addr_q[31:5] || widx > IDX_SCRATCH) begin
            wr_resp = RESP_SLVERR;
        end else begin
            case (widx)
                IDX_CTRL: if (w_strb_q[0]) begin
                    wr_ie_we = 1'b1;
                    // Soft reset takes priority and silently drops a simultaneous start.
                    if (w_data_q[1]) begin
                        wr_srst = 1'b1;
                    end else if (w_data_q[0]) begin
                        if (busy_i) wr_resp  = RESP_SLVERR;
                        else        wr_start = 1'b1;
                    end
                end
                IDX_STATUS: wr_done_clr = w_strb_q[0] && w_data_q[1];
                IDX_DIM: if (w_strb_q[0]) begin
                    if (w_data_q[7:0] == 8'd0 || w_data_q[7:0] > DIM_MAX_V) wr_resp   = RESP_SLVERR;
                    else                                                  wr_dim_we = 1'b1;
                end
                IDX_SCRATCH: wr_scratch_we = w_strb_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            start_o    <= 1'b0;
            soft_rst_o <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_held   <= 1'b1;
                aw_addr_q <= awaddr[31:2];
            end
            if (wvalid && wready) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            start_o    <= commit && wr_start;
            soft_rst_o <= commit && wr_srst;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_resp;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            done_cnt  <= '0;
            dim_q     <= DIM_RST_V;
            scratch_q <= '0;
            irq_o     <= 1'b0;
        end else begin
            // Soft reset beats a coincident done_i; a done_i beats a coincident W1C.
            if (commit && wr_srst) begin
                ie_q     <= 1'b0;
                done_q   <= 1'b0;
                done_cnt <= '0;
                dim_q    <= DIM_RST_V;
            end else begin
                if (commit && wr_ie_we) ie_q <= w_data_q[2];
                if (done_i)                      done_q <= 1'b1;
                else if (commit && wr_done_clr)  done_q <= 1'b0;
                if (done_i) done_cnt <= done_cnt + 32'd1;
                if (commit && wr_dim_we) dim_q <= w_data_q[7:0];
            end
            for (int i = 0; i < 4; i++) begin
                if (commit && wr_scratch_we[i]) scratch_q[8*i +: 8] <= w_data_q[8*i +: 8];
            end
            irq_o <= done_q && ie_q;
        end
    end

    logic [2:0]  ridx;
    logic        rd_bad;
    logic [31:0] rd_val;

    always_comb begin
        ridx   = araddr[4:2];
        rd_bad = |araddr[31:5] || ridx > IDX_SCRATCH;
        rd_val = '0;
        case (ridx)
            IDX_CTRL:    rd_val = {29'd0, ie_q, 2'b00};
            IDX_STATUS:  rd_val = {30'd0, done_q, busy_i};
            IDX_DIM:     rd_val = {24'd0, dim_q};
            IDX_CNT:     rd_val = done_cnt;
            IDX_SCRATCH: rd_val = scratch_q;
            default:     rd_val = '0;
        endcase
        if (rd_bad) rd_val = '0;
    end

    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= rd_bad ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule
